// File: rtl/mul_share_pkg.sv
// Shared constants, id-width helper and FIFO entry type for the shared-multiplier arbiter.
package mul_share_pkg;

    localparam int unsigned DefNreq   = 4;
    localparam int unsigned DefW      = 4;
    localparam int unsigned DefMulLat = 1;

    // Entry fields are sized for the largest supported config (NREQ <= 8, W <= 8).
    localparam int unsigned RespIdW = 3;
    localparam int unsigned RespPW  = 16;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [RespIdW-1:0] id;
        logic [RespPW-1:0]  p;
    } resp_t;

endpackage

// File: rtl/mul_share_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr_i, modulo NREQ.
module mul_share_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IdW  = 2
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IdW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IdW-1:0]  gnt_id_o,
    output logic            gnt_any_o
);

    always_comb begin
        int unsigned idx;
        logic        found;
        idx       = 0;
        found     = 1'b0;
        gnt_o     = '0;
        gnt_id_o  = '0;
        if (en_i) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = (32'(ptr_i) + k) % NREQ;
                if (!found && valid_i[idx]) begin
                    found       = 1'b1;
                    gnt_o[idx]  = 1'b1;
                    gnt_id_o    = IdW'(idx);
                end
            end
        end
        gnt_any_o = found;
    end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin scheduler sharing one registered multiplier among NREQ requesters.
// Optional per-requester grant counters are enabled by defining MUL_SHARE_ARB_STATS_EN.
module mul_share_arb #(
    parameter int unsigned NREQ    = mul_share_pkg::DefNreq,
    parameter int unsigned W       = mul_share_pkg::DefW,
    parameter int unsigned MUL_LAT = mul_share_pkg::DefMulLat
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NREQ-1:0]                   req_valid_i,
    input  logic [NREQ*W-1:0]                 req_a_i,
    input  logic [NREQ*W-1:0]                 req_b_i,
    output logic [NREQ-1:0]                   req_ready_o,
    output logic [W-1:0]                      mul_a_o,
    output logic [W-1:0]                      mul_b_o,
    output logic                              mul_en_o,
    input  logic [2*W-1:0]                    mul_p_i,
    output logic                              resp_valid_o,
    input  logic                              resp_ready_i,
    output logic [mul_share_pkg::id_width(NREQ)-1:0] resp_id_o,
    output logic [2*W-1:0]                    resp_p_o
`ifdef MUL_SHARE_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]                grant_cnt_o
`endif
);
    import mul_share_pkg::*;

    localparam int unsigned IdW  = id_width(NREQ);
    localparam int unsigned D    = MUL_LAT + 2;
    localparam int unsigned PtrW = id_width(D);
    localparam int unsigned CntW = $clog2(D + 1);

    logic [IdW-1:0]  ptr_q;
    logic [NREQ-1:0] gnt;
    logic [IdW-1:0]  gnt_id;
    logic            gnt_any;
    logic            issue_ok;

    logic [MUL_LAT-1:0] tag_vld_q;
    logic [IdW-1:0]     tag_id_q [MUL_LAT];

    resp_t          fifo_q [D];
    resp_t          head;
    resp_t          hold_q;
    resp_t          sel;
    logic [PtrW-1:0] wr_q, rd_q;
    logic [CntW-1:0] cnt_q;
    logic            push, pop;

    // Credits count both queued results and products still in the multiplier.
    always_comb begin
        int unsigned inflight;
        inflight = 0;
        for (int unsigned i = 0; i < MUL_LAT; i++) begin
            inflight = inflight + 32'(tag_vld_q[i]);
        end
        issue_ok = ((32'(cnt_q) + inflight) < D) && !rst_i;
    end

    mul_share_rr_pick #(
        .NREQ (NREQ),
        .IdW  (IdW)
    ) u_pick (
        .valid_i   (req_valid_i),
        .ptr_i     (ptr_q),
        .en_i      (issue_ok),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_any_o (gnt_any)
    );

    assign req_ready_o = gnt;
    assign mul_en_o    = gnt_any;
    assign mul_a_o     = gnt_any ? req_a_i[gnt_id*W +: W] : '0;
    assign mul_b_o     = gnt_any ? req_b_i[gnt_id*W +: W] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (gnt_any) begin
            ptr_q <= (gnt_id == IdW'(NREQ - 1)) ? '0 : gnt_id + IdW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_vld_q <= '0;
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0] <= gnt_any;
            tag_id_q[0]  <= gnt_id;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    assign push = tag_vld_q[MUL_LAT-1];
    assign pop  = (cnt_q != '0) && resp_ready_i;
    assign head = fifo_q[rd_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            hold_q <= '0;
            for (int unsigned i = 0; i < D; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wr_q].id <= RespIdW'(tag_id_q[MUL_LAT-1]);
                fifo_q[wr_q].p  <= RespPW'(mul_p_i);
                wr_q            <= (wr_q == PtrW'(D - 1)) ? '0 : wr_q + PtrW'(1);
            end
            if (pop) begin
                hold_q <= head;
                rd_q   <= (rd_q == PtrW'(D - 1)) ? '0 : rd_q + PtrW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (!push && pop) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    // Outputs keep the last popped entry visible while the FIFO is empty.
    assign resp_valid_o = (cnt_q != '0);
    assign sel          = resp_valid_o ? head : hold_q;
    assign resp_id_o    = sel.id[IdW-1:0];
    assign resp_p_o     = sel.p[2*W-1:0];

`ifdef MUL_SHARE_ARB_STATS_EN
    logic [15:0] stat_q [NREQ];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (gnt[i] && stat_q[i] != 16'hFFFF) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant_cnt_o[i*16 +: 16] = stat_q[i];
        end
    end
`endif

endmodule
